// File: rtl/seq_chunk_adder_if.sv
// rtl/seq_chunk_adder_if.sv - operand/result handshake bundle for seq_chunk_adder
// OVF member exists only when SEQ_CHUNK_ADDER_OVF_EN is defined.
interface seq_chunk_adder_if #(
  parameter int WIDTH = 8
);
  logic             START;
  logic             IN_READY;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cin;
  logic [WIDTH-1:0] SUM;
  logic             Cout;
  logic             DONE;
  logic             ACK;
`ifdef SEQ_CHUNK_ADDER_OVF_EN
  logic             OVF;
`endif

  modport master (
    output START, A, B, Cin, ACK,
`ifdef SEQ_CHUNK_ADDER_OVF_EN
    input  OVF,
`endif
    input  IN_READY, SUM, Cout, DONE
  );

  modport slave (
    input  START, A, B, Cin, ACK,
`ifdef SEQ_CHUNK_ADDER_OVF_EN
    output OVF,
`endif
    output IN_READY, SUM, Cout, DONE
  );
endinterface

// File: rtl/seq_chunk_adder.sv
// rtl/seq_chunk_adder.sv - WIDTH-bit adder processing CHUNK bits per clock via a registered carry
// Define SEQ_CHUNK_ADDER_OVF_EN to add the signed-overflow output OVF.
module seq_chunk_adder #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 2
) (
  input  logic CLK,
  input  logic RST,
  seq_chunk_adder_if.slave bus
);
  localparam int CH_SAFE = (CHUNK < 1) ? 1 : CHUNK;
  localparam int NCHUNK  = WIDTH / CH_SAFE;
  localparam int CW      = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int RW      = (NCHUNK > 1) ? WIDTH - CH_SAFE : 1;

  generate
    if (CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CH_SAFE) != 0) begin : g_bad_param
      $error("seq_chunk_adder: WIDTH must be a non-zero multiple of CHUNK");
    end
  endgenerate

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [RW-1:0]    res_q, res_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CHUNK:0]   csum;
  logic [RW-1:0]    res_shift;
  logic [WIDTH-1:0] full_res;
  logic             last;

  assign csum = {1'b0, a_q[CHUNK-1:0]} + {1'b0, b_q[CHUNK-1:0]} + {{CHUNK{1'b0}}, carry_q};
  assign last = (cnt_q == CW'(NCHUNK - 1));

  // res_q holds only the chunks already finished; the current chunk joins it at the top on the final edge
  generate
    if (NCHUNK == 1) begin : g_single
      assign full_res  = csum[CHUNK-1:0];
      assign res_shift = res_q;
    end else begin : g_multi
      assign full_res = {csum[CHUNK-1:0], res_q};
      if (NCHUNK == 2) begin : g_two
        assign res_shift = csum[CHUNK-1:0];
      end else begin : g_many
        assign res_shift = {csum[CHUNK-1:0], res_q[RW-1:CHUNK]};
      end
    end
  endgenerate

  always_ff @(posedge CLK) begin
    if (RST) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.START) state_d = S_RUN;
      S_RUN:   if (last)      state_d = S_DONE;
      S_DONE:  if (bus.ACK)   state_d = S_IDLE;
      default:                state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.IN_READY = (state_q == S_IDLE);
    bus.DONE     = (state_q == S_DONE);
  end

  assign bus.SUM  = sum_q;
  assign bus.Cout = cout_q;

  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    if (state_q == S_IDLE && bus.START) begin
      a_d     = bus.A;
      b_d     = bus.B;
      carry_d = bus.Cin;
      cnt_d   = '0;
    end else if (state_q == S_RUN) begin
      a_d     = a_q >> CHUNK;
      b_d     = b_q >> CHUNK;
      res_d   = res_shift;
      carry_d = csum[CHUNK];
      cnt_d   = cnt_q + CW'(1);
      if (last) begin
        sum_d  = full_res;
        cout_d = csum[CHUNK];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef SEQ_CHUNK_ADDER_OVF_EN
  logic ovf_q, ovf_d;

  // carry into the MSB is recovered from the MSB sum bit and its operand bits
  always_comb begin
    ovf_d = ovf_q;
    if (state_q == S_RUN && last)
      ovf_d = csum[CHUNK] ^ (csum[CHUNK-1] ^ a_q[CHUNK-1] ^ b_q[CHUNK-1]);
  end

  always_ff @(posedge CLK) begin
    if (RST) ovf_q <= 1'b0;
    else     ovf_q <= ovf_d;
  end

  assign bus.OVF = ovf_q;
`endif
endmodule

// File: tb/tb_seq_chunk_adder.sv
// tb/tb_seq_chunk_adder.sv - directed and model-checked bench for seq_chunk_adder
// Instances: WIDTH=8 with CHUNK=1,2,4,8 (index 0..3) plus WIDTH=16, CHUNK=1.
module tb_seq_chunk_adder;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       st[4];
  logic [7:0] av[4];
  logic [7:0] bv[4];
  logic       ci[4];
  logic       ak[4];
  logic       rdy[4];
  logic       dn[4];
  logic       co[4];
  logic [7:0] sm[4];
`ifdef SEQ_CHUNK_ADDER_OVF_EN
  logic       ov[4];
`endif

  int checks = 0;
  int errors = 0;

  for (genvar g = 0; g < 4; g++) begin : g_cfg
    seq_chunk_adder_if #(.WIDTH(8)) ifc ();
    assign ifc.START = st[g];
    assign ifc.A     = av[g];
    assign ifc.B     = bv[g];
    assign ifc.Cin   = ci[g];
    assign ifc.ACK   = ak[g];
    assign rdy[g]    = ifc.IN_READY;
    assign dn[g]     = ifc.DONE;
    assign co[g]     = ifc.Cout;
    assign sm[g]     = ifc.SUM;
`ifdef SEQ_CHUNK_ADDER_OVF_EN
    assign ov[g]     = ifc.OVF;
`endif
    seq_chunk_adder #(.WIDTH(8), .CHUNK(1 << g)) dut (
      .CLK (clk),
      .RST (rst),
      .bus (ifc)
    );
  end

  seq_chunk_adder_if #(.WIDTH(16)) w16 ();
  seq_chunk_adder #(.WIDTH(16), .CHUNK(1)) dut_w16 (
    .CLK (clk),
    .RST (rst),
    .bus (w16)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_op(input int k, input logic [7:0] a, input logic [7:0] b, input logic cin,
                       input logic [7:0] esum, input logic ecout, input logic eovf,
                       input int ackd, input string name);
    int lat;
    checks++;
    if (rdy[k] !== 1'b1) begin errors++; $display("FAIL %s_ready_idle cfg%0d got %b want 1", name, k, rdy[k]); end
    av[k] = a; bv[k] = b; ci[k] = cin; st[k] = 1'b1;
    tick();
    st[k] = 1'b0;
    checks++;
    if (rdy[k] !== 1'b0) begin errors++; $display("FAIL %s_ready_run cfg%0d got %b want 0", name, k, rdy[k]); end
    lat = 0;
    while (dn[k] !== 1'b1 && lat < 40) begin
      tick();
      lat++;
    end
    checks++;
    if (lat != (8 >> k)) begin errors++; $display("FAIL %s_latency cfg%0d got %0d want %0d", name, k, lat, 8 >> k); end
    checks++;
    if (sm[k] !== esum) begin errors++; $display("FAIL %s_sum cfg%0d got %h want %h", name, k, sm[k], esum); end
    checks++;
    if (co[k] !== ecout) begin errors++; $display("FAIL %s_cout cfg%0d got %b want %b", name, k, co[k], ecout); end
`ifdef SEQ_CHUNK_ADDER_OVF_EN
    checks++;
    if (ov[k] !== eovf) begin errors++; $display("FAIL %s_ovf cfg%0d got %b want %b", name, k, ov[k], eovf); end
`else
    if (eovf === 1'bx) $display("note: ovf expectation unknown");
`endif
    checks++;
    if (rdy[k] !== 1'b0) begin errors++; $display("FAIL %s_ready_done cfg%0d got %b want 0", name, k, rdy[k]); end
    if (ackd >= 0) begin
      repeat (ackd) tick();
      ak[k] = 1'b1;
      tick();
      ak[k] = 1'b0;
      checks++;
      if (dn[k] !== 1'b0 || rdy[k] !== 1'b1) begin
        errors++;
        $display("FAIL %s_ack cfg%0d got done=%b ready=%b want done=0 ready=1", name, k, dn[k], rdy[k]);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      st[k] = 1'b0; av[k] = '0; bv[k] = '0; ci[k] = 1'b0; ak[k] = 1'b0;
    end
    w16.START = 1'b0; w16.A = '0; w16.B = '0; w16.Cin = 1'b0; w16.ACK = 1'b0;
    repeat (2) tick();
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (rdy[k] !== 1'b1 || dn[k] !== 1'b0 || sm[k] !== 8'h00 || co[k] !== 1'b0) begin
        errors++;
        $display("FAIL reset cfg%0d got ready=%b done=%b sum=%h cout=%b want 1 0 00 0", k, rdy[k], dn[k], sm[k], co[k]);
      end
    end
    checks++;
    if (w16.IN_READY !== 1'b1 || w16.DONE !== 1'b0 || w16.SUM !== 16'h0 || w16.Cout !== 1'b0) begin
      errors++;
      $display("FAIL reset_w16 got ready=%b done=%b sum=%h cout=%b want 1 0 0000 0", w16.IN_READY, w16.DONE, w16.SUM, w16.Cout);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    do_op(1, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1, "wrap");
    do_op(1, 8'h5A, 8'h25, 1'b1, 8'h80, 1'b0, 1'b1, 0, "ovf_pos");
    do_op(1, 8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0, 2, "plain");
  endtask

  task automatic test_back_pressure();
    do_op(1, 8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0, -1, "bp_op");
    av[1] = 8'h01; bv[1] = 8'h00;
    for (int i = 0; i < 10; i++) begin
      st[1] = (i % 2 == 0);
      tick();
      checks++;
      if (dn[1] !== 1'b1 || sm[1] !== 8'h30 || co[1] !== 1'b0 || rdy[1] !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold cyc%0d got done=%b sum=%h cout=%b ready=%b want 1 30 0 0", i, dn[1], sm[1], co[1], rdy[1]);
      end
    end
    st[1] = 1'b0;
    ak[1] = 1'b1;
    tick();
    ak[1] = 1'b0;
    checks++;
    if (rdy[1] !== 1'b1 || dn[1] !== 1'b0 || sm[1] !== 8'h30) begin
      errors++;
      $display("FAIL bp_release got ready=%b done=%b sum=%h want 1 0 30", rdy[1], dn[1], sm[1]);
    end
    do_op(1, 8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 1'b0, 0, "bp_next");
  endtask

  task automatic test_reset_mid();
    logic seen;
    av[1] = 8'hAA; bv[1] = 8'h55; ci[1] = 1'b1; st[1] = 1'b1;
    tick();
    st[1] = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (rdy[1] !== 1'b1 || dn[1] !== 1'b0 || sm[1] !== 8'h00 || co[1] !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid got ready=%b done=%b sum=%h cout=%b want 1 0 00 0", rdy[1], dn[1], sm[1], co[1]);
    end
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (dn[1] === 1'b1) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin errors++; $display("FAIL rst_no_done got %b want 0", seen); end
    do_op(1, 8'h03, 8'h04, 1'b0, 8'h07, 1'b0, 1'b0, 1, "post_rst");
  endtask

  task automatic test_chunk_eq_width();
    do_op(3, 8'h80, 8'h80, 1'b1, 8'h01, 1'b1, 1'b1, 0, "c8");
    do_op(0, 8'h80, 8'h80, 1'b1, 8'h01, 1'b1, 1'b1, 0, "c1");
    do_op(2, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 3, "c4");
  endtask

  task automatic test_w16();
    int lat;
    w16.A = 16'hFFFF; w16.B = 16'h0000; w16.Cin = 1'b1; w16.START = 1'b1;
    tick();
    w16.START = 1'b0;
    lat = 0;
    while (w16.DONE !== 1'b1 && lat < 40) begin
      tick();
      lat++;
    end
    checks++;
    if (lat != 16) begin errors++; $display("FAIL w16_latency got %0d want 16", lat); end
    checks++;
    if (w16.SUM !== 16'h0000 || w16.Cout !== 1'b1) begin
      errors++;
      $display("FAIL w16_result got sum=%h cout=%b want 0000 1", w16.SUM, w16.Cout);
    end
`ifdef SEQ_CHUNK_ADDER_OVF_EN
    checks++;
    if (w16.OVF !== 1'b0) begin errors++; $display("FAIL w16_ovf got %b want 0", w16.OVF); end
`endif
    w16.ACK = 1'b1;
    tick();
    w16.ACK = 1'b0;
    checks++;
    if (w16.IN_READY !== 1'b1) begin errors++; $display("FAIL w16_ack got ready=%b want 1", w16.IN_READY); end
  endtask

  task automatic test_random();
    logic [7:0] a, b, s;
    logic       cin, c, ov_e;
    for (int k = 0; k < 4; k++) begin
      for (int n = 0; n < 1000; n++) begin
        a = 8'($urandom);
        b = 8'($urandom);
        cin = 1'($urandom);
        {c, s} = {1'b0, a} + {1'b0, b} + {8'h00, cin};
        ov_e = (a[7] == b[7]) && (s[7] != a[7]);
        do_op(k, a, b, cin, s, c, ov_e, int'($urandom_range(0, 5)), "rand");
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_pressure();
    test_reset_mid();
    test_chunk_eq_width();
    test_w16();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/seq_chunk_adder.md
Name: seq_chunk_adder

Overview:
- Multi-cycle, parametrised successor to the team's 2-bit ripple adder core.
- Adds two WIDTH-bit operands plus carry-in, CHUNK bits per clock, through a registered carry.
- Operands enter and results leave over valid/ready-style handshakes.
- Sits between operand-supply logic and result consumers where area matters more than latency.

Parameters:
- WIDTH, 8, operand and sum width in bits; must be an integer multiple of CHUNK.
- CHUNK, 2, bits added per RUN cycle (1..WIDTH); NCHUNK = WIDTH/CHUNK.

Ports:
- CLK  in  1  single clock; all state updates on rising edge.
- RST  in  1  synchronous, active-high reset.
- START  in  1  operand valid; accepted only while IN_READY=1.
- IN_READY  out  1  high only in IDLE.
- A  in  WIDTH  operand A, sampled at the accept edge.
- B  in  WIDTH  operand B, sampled at the accept edge.
- Cin  in  1  carry-in, sampled at the accept edge.
- SUM  out  WIDTH  result (A+B+Cin) mod 2^WIDTH, registered.
- Cout  out  1  carry out of bit WIDTH-1, registered.
- DONE  out  1  result valid; held until ACK.
- ACK  in  1  result consumed; effective only while DONE=1.

Behaviour:
- Clock and reset: one clock, CLK; reset is RST, synchronous and active-high.
- RST dominates every other input on any edge, including mid-operation.
  - State goes to IDLE.
  - SUM=0, Cout=0, DONE=0, carry register=0, chunk counter=0.
  - Any in-flight operation is discarded with no partial result.
- State machine, states IDLE, RUN, DONE.
  - IDLE: IN_READY=1. On START=1, load A and B into internal shift registers, load the carry register with Cin, clear the counter, go to RUN.
  - RUN: each edge adds the low CHUNK bits of both shift registers plus the carry register.
    - The CHUNK-bit partial sum shifts into the result shift register from the MSB side.
    - The carry register takes the chunk carry-out.
    - The operand registers shift right by CHUNK and the counter increments.
    - On the edge that processes chunk NCHUNK-1, copy the full result to SUM, the final carry to Cout, and go to DONE.
  - DONE: DONE=1 and SUM/Cout are stable. On ACK=1, go to IDLE and DONE deasserts on that edge.
- Latency: DONE rises exactly NCHUNK edges after the accept edge (4 with defaults); throughput is one operation per NCHUNK+2 cycles.
- START while IN_READY=0 is ignored: no queueing and no side effect.
- ACK outside DONE is ignored.
- SUM/Cout keep the last result through IDLE and RUN, and change only on entry to DONE or on reset.
- IN_READY is a registered state decode with no combinational path from any input.
- Wrap-around: sum is modulo 2^WIDTH. Example: 0xFF+0x01+0 gives SUM=0x00, Cout=1.
- Boundary CHUNK=WIDTH: NCHUNK=1, so RUN lasts one cycle and DONE appears 1 edge after accept.
- Boundary CHUNK=1: pure bit-serial operation, WIDTH RUN cycles.
- Invalid parameters (WIDTH % CHUNK != 0, or CHUNK=0) must be rejected at elaboration.

Optional Feature:
- Macro SEQ_CHUNK_ADDER_OVF_EN.
- Defined:
  - Adds output port OVF (out, 1), signed two's-complement overflow.
  - OVF = carry into bit WIDTH-1 XOR Cout, captured with SUM on entry to DONE.
  - Reset value 0; stable until the next DONE entry.
- Undefined: port OVF is absent and no related logic is generated.

Test Plan:
- Defaults, A=0xFF, B=0x01, Cin=0, START one cycle → DONE high 4 edges after the accept edge; SUM=0x00, Cout=1; IN_READY=0 for the RUN and DONE cycles.
- A=0x5A, B=0x25, Cin=1 → SUM=0x80, Cout=0; with SEQ_CHUNK_ADDER_OVF_EN, OVF=1. Then A=0x10, B=0x20, Cin=0 → SUM=0x30, Cout=0, OVF=0.
- Back-pressure:
  - Hold ACK=0 for 10 cycles after DONE while pulsing START with A=0x01 → DONE, SUM and Cout stay constant and the new START is ignored.
  - ACK=1 → IDLE next edge; a following START is accepted.
- Reset mid-operation: accept A=0xAA, B=0x55, Cin=1, assert RST on the 2nd RUN cycle → next edge: IDLE, SUM=0, Cout=0, DONE=0, IN_READY=1. No DONE pulse follows; a fresh 0x03+0x04 gives SUM=0x07.
- Parameter sweep:
  - WIDTH=8, CHUNK=8: latency 1 edge; 0x80+0x80+1 → SUM=0x01, Cout=1.
  - WIDTH=16, CHUNK=1: latency 16 edges; 0xFFFF+0x0000+1 → SUM=0x0000, Cout=1.
- Randomised 1000 operations per configuration (CHUNK ∈ {1,2,4,8}, WIDTH=8) checked against a reference model {Cout,SUM}=A+B+Cin, with random ACK delays of 0–5 cycles.
